// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: captures a word and repeat count on start, then shifts the word
// out MSB first, repeat_n+1 times back-to-back, with a hold input that stretches the current bit.
module serial_pattern_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic             hold,
  output logic             outp,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IdxW-1:0] IdxMax = IdxW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StFinish = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] word_q;
  logic [IdxW-1:0]  idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      shreg_q <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            shreg_q <= data;
            word_q  <= data;
            cnt_q   <= repeat_n;
            idx_q   <= IdxMax;
            busy_q  <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          if (!hold) begin
            if (idx_q != '0) begin
              shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
              idx_q   <= idx_q - IdxW'(1);
            end else if (cnt_q != '0) begin
              // Reload from the captured copy so later changes on data cannot leak in.
              shreg_q <= word_q;
              idx_q   <= IdxMax;
              cnt_q   <= cnt_q - CNT_W'(1);
            end else begin
              done_q  <= 1'b1;
              state_q <= StFinish;
            end
          end
        end
        StFinish: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign outp  = (state_q == StShift) & shreg_q[WIDTH-1];
  assign valid = (state_q == StShift) & ~hold;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx: stimulus queues expected bits and done markers,
// a negedge monitor pops them whenever the DUT presents a valid bit or a done pulse.
module tb_serial_pattern_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic [3:0] repeat_n = 4'd0;
  logic       hold = 1'b0;
  logic       outp, valid, busy, done;

  typedef struct {
    bit is_done;
    bit val;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  serial_pattern_tx #(.WIDTH(8), .CNT_W(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .data    (data),
    .repeat_n(repeat_n),
    .hold    (hold),
    .outp    (outp),
    .valid   (valid),
    .busy    (busy),
    .done    (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_bit(input bit v);
    q.push_back('{is_done: 1'b0, val: v});
  endtask

  task automatic push_word(input logic [7:0] w, input int reps);
    for (int r = 0; r < reps; r++)
      for (int i = 7; i >= 0; i--) push_bit(w[i]);
    q.push_back('{is_done: 1'b1, val: 1'b0});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue start so it is sampled at the next edge (E0); returns at the start of cycle 1.
  task automatic accept();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Monitor: every valid bit and every done pulse must match the head of the queue.
  always @(negedge clock) begin
    if (valid) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL mon_bit: got unexpected bit %0b, required no valid bit (t=%0t)", outp, $time);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.is_done || outp !== mon_e.val) begin
          n_err++;
          $display("FAIL mon_bit: got bit %0b, required %s (t=%0t)", outp,
                   mon_e.is_done ? "done pulse" : (mon_e.val ? "bit 1" : "bit 0"), $time);
        end
      end
    end
    if (done) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL mon_done: got unexpected done, required none (t=%0t)", $time);
      end else begin
        mon_e = q.pop_front();
        if (!mon_e.is_done) begin
          n_err++;
          $display("FAIL mon_done: got done, required bit %0b (t=%0t)", mon_e.val, $time);
        end
      end
    end
  end

  initial begin
    // Reset held with start high: everything stays zero.
    start = 1'b1;
    data  = 8'hDC;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk("rst_outp", outp, 0);
      chk("rst_valid", valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_valid", valid, 0);
      step();
    end

    // Single word 1101_1100.
    data = 8'hDC;
    repeat_n = 4'd0;
    push_word(8'hDC, 1);
    accept();
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      chk("single_busy", busy, int'(c <= 9));
      chk("single_done", done, int'(c == 9));
      chk("single_valid", valid, int'(c <= 8));
      step();
    end
    chk("single_drain", q.size(), 0);

    // A5 three times; data changes mid-transfer must not matter.
    data = 8'hA5;
    repeat_n = 4'd2;
    push_word(8'hA5, 3);
    accept();
    for (int c = 1; c <= 26; c++) begin
      if (c == 3) data = 8'h00;
      @(negedge clock);
      chk("rep_busy", busy, int'(c <= 25));
      chk("rep_done", done, int'(c == 25));
      chk("rep_valid", valid, int'(c <= 24));
      step();
    end
    chk("rep_drain", q.size(), 0);

    // Hold during cycles 3-5 stretches bit 5 of F0.
    data = 8'hF0;
    repeat_n = 4'd0;
    push_word(8'hF0, 1);
    accept();
    for (int c = 1; c <= 13; c++) begin
      hold = (c >= 3 && c <= 5);
      @(negedge clock);
      chk("hold_done", done, int'(c == 12));
      chk("hold_valid", valid, int'(c <= 11 && !(c >= 3 && c <= 5)));
      if (c >= 3 && c <= 6) chk("hold_outp", outp, 1);
      step();
    end
    hold = 1'b0;
    chk("hold_drain", q.size(), 0);

    // Start while busy is ignored; start one edge after FINISH is accepted.
    data = 8'h96;
    repeat_n = 4'd0;
    push_word(8'h96, 1);
    accept();
    for (int c = 1; c <= 10; c++) begin
      start = (c == 2 || c == 5 || c == 9);
      if (c == 2) begin
        data = 8'h3C;
        repeat_n = 4'd1;
      end
      if (c == 10) begin
        repeat_n = 4'd0;
        push_word(8'h3C, 1);
        start = 1'b1;
      end
      @(negedge clock);
      chk("busy_ign_busy", busy, int'(c <= 9));
      chk("busy_ign_done", done, int'(c == 9));
      step();
    end
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      chk("b2b_busy", busy, int'(c <= 9));
      chk("b2b_done", done, int'(c == 9));
      step();
    end
    chk("b2b_drain", q.size(), 0);

    // Asynchronous reset mid-cycle 4 of a two-word transfer.
    data = 8'hB4;
    repeat_n = 4'd1;
    push_bit(1'b1);
    push_bit(1'b0);
    push_bit(1'b1);
    accept();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      step();
    end
    #2;
    reset = 1'b0;
    #1;
    chk("abort_outp", outp, 0);
    chk("abort_valid", valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    step();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("abort_idle_busy", busy, 0);
      chk("abort_idle_done", done, 0);
      step();
    end
    chk("abort_drain", q.size(), 0);
    push_word(8'hB4, 2);
    accept();
    for (int c = 1; c <= 18; c++) begin
      @(negedge clock);
      chk("restart_busy", busy, int'(c <= 17));
      chk("restart_done", done, int'(c == 17));
      step();
    end
    chk("restart_drain", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
